// File: rtl/intra_pkg.sv
// Shared definitions for intra 4x4 SAD mode selection: FSM states, width helpers, mode indices.
// RESER_RES_CLIP_EN selects the residual width (defined: PIX_W saturated, undefined: PIX_W+1 full).
package intra_pkg;

    typedef enum logic [1:0] {ACCUM, SELECT, DONE} state_t;

    localparam int MODE_V   = 0;
    localparam int MODE_H   = 1;
    localparam int MODE_DC  = 2;
    localparam int MODE_DDL = 3;
    localparam int MODE_DDR = 4;
    localparam int MODE_VR  = 5;
    localparam int MODE_HD  = 6;
    localparam int MODE_VL  = 7;
    localparam int MODE_HU  = 8;

    function automatic int sad_w(input int pix_w, input int blk_pix);
        return pix_w + $clog2(blk_pix);
    endfunction

    function automatic int res_w(input int pix_w);
`ifdef RESER_RES_CLIP_EN
        return pix_w;
`else
        return pix_w + 1;
`endif
    endfunction

endpackage

// File: rtl/reser_abs_lane.sv
// One prediction mode: per-lane residual mb - pred and the sum of absolute residuals of a beat.
// With RESER_RES_CLIP_EN the residual output saturates; the absolute sum always uses the full value.
module reser_abs_lane
    import intra_pkg::*;
#(
    parameter int LANES = 4,
    parameter int PIX_W = 8,
    parameter int RES_W = res_w(PIX_W),
    parameter int SUM_W = PIX_W + $clog2(LANES) + 1
) (
    input  logic [LANES*PIX_W-1:0] mb,
    input  logic [LANES*PIX_W-1:0] pred,
    output logic [LANES*RES_W-1:0] res,
    output logic [SUM_W-1:0]       abs_sum
);

    logic [LANES*PIX_W-1:0] mag;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic signed [PIX_W:0] diff;

        assign diff = $signed({1'b0, mb[l*PIX_W +: PIX_W]}) - $signed({1'b0, pred[l*PIX_W +: PIX_W]});
        assign mag[l*PIX_W +: PIX_W] = diff[PIX_W] ? PIX_W'(-diff) : diff[PIX_W-1:0];

`ifdef RESER_RES_CLIP_EN
        localparam logic signed [PIX_W:0] RES_MAX = (PIX_W+1)'((1 << (PIX_W-1)) - 1);
        localparam logic signed [PIX_W:0] RES_MIN = -RES_MAX - 1;

        assign res[l*RES_W +: RES_W] = (diff > RES_MAX) ? RES_W'(RES_MAX) :
                                       (diff < RES_MIN) ? RES_W'(RES_MIN) : diff[RES_W-1:0];
`else
        assign res[l*RES_W +: RES_W] = diff;
`endif
    end

    // NOTE: combinational accumulation uses blocking '=' and starts from a default, so no latch forms.
    always_comb begin
        abs_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            abs_sum = abs_sum + SUM_W'(mag[i*PIX_W +: PIX_W]);
        end
    end

endmodule

// File: rtl/reser_sad_select.sv
// Accumulates per-mode SAD over one block of beats, then scans the modes to pick the lowest-SAD one.
// Residual width/saturation is selected by RESER_RES_CLIP_EN (see intra_pkg).
module reser_sad_select
    import intra_pkg::*;
#(
    parameter int NUM_MODES = 9,
    parameter int PIX_W     = 8,
    parameter int LANES     = 4,
    parameter int BLK_PIX   = 16,
    localparam int SAD_W    = sad_w(PIX_W, BLK_PIX),
    localparam int RES_W    = res_w(PIX_W),
    localparam int MODE_W   = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [LANES*PIX_W-1:0]           mb,
    input  logic [NUM_MODES*LANES*PIX_W-1:0] pred,
    input  logic [NUM_MODES-1:0]             mode_mask,
    output logic [NUM_MODES*LANES*RES_W-1:0] res,
    output logic                             res_valid,
    output logic                             sad_valid,
    input  logic                             sad_ready,
    output logic [MODE_W-1:0]                best_mode,
    output logic [SAD_W-1:0]                 best_sad,
    output logic                             none_avail
);

    localparam int BEATS = BLK_PIX / LANES;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [MODE_W-1:0] LAST_MODE = MODE_W'(NUM_MODES - 1);

    state_t                           state;
    logic [CNT_W-1:0]                 beat_cnt;
    logic [MODE_W-1:0]                sel_idx;
    logic [NUM_MODES-1:0]             mask_r;
    logic                             found;
    logic [SAD_W-1:0]                 acc      [NUM_MODES];
    logic [SAD_W-1:0]                 beat_sad [NUM_MODES];
    logic [NUM_MODES*LANES*RES_W-1:0] res_d;
    logic                             accept;
    logic                             better;

    assign in_ready = (state == ACCUM);
    assign accept   = in_valid && in_ready;
    // Strict '<' keeps the lower index on ties since modes are scanned upward.
    assign better   = mask_r[sel_idx] && (!found || (acc[sel_idx] < best_sad));

    for (genvar m = 0; m < NUM_MODES; m++) begin : g_mode
        reser_abs_lane #(
            .LANES (LANES),
            .PIX_W (PIX_W),
            .RES_W (RES_W),
            .SUM_W (SAD_W)
        ) u_abs_lane (
            .mb      (mb),
            .pred    (pred[m*LANES*PIX_W +: LANES*PIX_W]),
            .res     (res_d[m*LANES*RES_W +: LANES*RES_W]),
            .abs_sum (beat_sad[m])
        );
    end

    // NOTE: the accumulators are a handful of flops, not a RAM, so reset clears them like other state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ACCUM;
            beat_cnt   <= '0;
            sel_idx    <= '0;
            mask_r     <= '0;
            found      <= 1'b0;
            for (int m = 0; m < NUM_MODES; m++) acc[m] <= '0;
            res        <= '0;
            res_valid  <= 1'b0;
            sad_valid  <= 1'b0;
            best_mode  <= '0;
            best_sad   <= '0;
            none_avail <= 1'b0;
        end else begin
            res_valid <= accept;
            if (accept) res <= res_d;

            case (state)
                ACCUM: begin
                    if (accept) begin
                        if (beat_cnt == '0) mask_r <= mode_mask;
                        for (int m = 0; m < NUM_MODES; m++) acc[m] <= acc[m] + beat_sad[m];
                        if (beat_cnt == LAST_BEAT) begin
                            beat_cnt   <= '0;
                            sel_idx    <= '0;
                            found      <= 1'b0;
                            best_mode  <= '0;
                            best_sad   <= '1;
                            none_avail <= 1'b0;
                            state      <= SELECT;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                SELECT: begin
                    if (better) begin
                        found     <= 1'b1;
                        best_mode <= sel_idx;
                        best_sad  <= acc[sel_idx];
                    end
                    if (sel_idx == LAST_MODE) begin
                        none_avail <= !(found || better);
                        sad_valid  <= 1'b1;
                        state      <= DONE;
                    end else begin
                        sel_idx <= sel_idx + 1'b1;
                    end
                end
                DONE: begin
                    if (sad_ready) begin
                        sad_valid <= 1'b0;
                        for (int m = 0; m < NUM_MODES; m++) acc[m] <= '0;
                        state <= ACCUM;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: doc/reser_sad_select.md
RESER_SAD_SELECT -- requirements
Module: reser_sad_select

Interface
REQ-001 SHALL have parameter NUM_MODES, default 9, meaning intra 4x4 prediction modes evaluated (mode index 0..NUM_MODES-1).
REQ-002 SHALL have parameter PIX_W, default 8, meaning pixel width in bits.
REQ-003 SHALL have parameter LANES, default 4, meaning pixels accepted per beat (one block row).
REQ-004 SHALL have parameter BLK_PIX, default 16, meaning pixels per block; BLK_PIX multiple of LANES.
REQ-005 SHALL have port clk  input  1  single clock, all state rising-edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port in_valid  input  1  beat of source/prediction pixels present.
REQ-008 SHALL have port in_ready  output  1  block can accept a beat.
REQ-009 SHALL have port mb  input  LANES x PIX_W  unsigned source pixels of current row.
REQ-010 SHALL have port pred  input  NUM_MODES x LANES x PIX_W  unsigned prediction per mode.
REQ-011 SHALL have port mode_mask  input  NUM_MODES  1 = mode available; sampled on first beat of block.
REQ-012 SHALL have port res  output  NUM_MODES x LANES x RES_W  signed residual mb - pred.
REQ-013 SHALL have port res_valid  output  1  res holds residuals of one beat.
REQ-014 SHALL have port sad_valid  output  1  best_mode/best_sad valid.
REQ-015 SHALL have port sad_ready  input  1  consumer accepts result.
REQ-016 SHALL have port best_mode  output  clog2(NUM_MODES)  lowest-SAD available mode.
REQ-017 SHALL have port best_sad  output  SAD_W = PIX_W+clog2(BLK_PIX)  SAD of best_mode.
REQ-018 SHALL have port none_avail  output  1  mode_mask was all zero.

Function
REQ-019 SHALL use FSM states ACCUM, SELECT, DONE; beat accepted when in_valid && in_ready; in_ready = (state == ACCUM).
REQ-020 SHALL register res and pulse res_valid the cycle after each accepted beat; no backpressure on res.
REQ-021 SHALL compute residuals at PIX_W+1 bits internally, range -255..255 for PIX_W=8.
REQ-022 SHALL add |residual| per lane into per-mode SAD_W-bit accumulators on each accepted beat; no overflow possible by width.
REQ-023 SHALL count beats 0..BLK_PIX/LANES-1; on acceptance of final beat go ACCUM->SELECT, counter wraps to 0.
REQ-024 SHALL in SELECT examine one mode per cycle, index 0 upward, NUM_MODES cycles, then go DONE.
REQ-025 SHALL skip masked modes; replace best only on strictly smaller SAD, so ties keep the lower index.
REQ-026 SHALL if mask all zero: best_mode = 0, best_sad = all ones, none_avail = 1.
REQ-027 SHALL assert sad_valid in DONE, exactly NUM_MODES+1 cycles after final beat acceptance; outputs stable while sad_valid && !sad_ready.
REQ-028 SHALL on sad_valid && sad_ready clear accumulators and go DONE->ACCUM; in_ready rises next cycle.
REQ-029 SHALL ignore in_valid in SELECT and DONE.

Reset
REQ-030 SHALL on reset low, asynchronously: state ACCUM, beat counter 0, accumulators 0, res 0, res_valid 0, sad_valid 0, best_mode 0, best_sad 0, none_avail 0.
REQ-031 SHALL abandon any partial block on reset mid-operation; first beat after release is row 0 of a new block.

Configuration
REQ-032 SHALL with RESER_RES_CLIP_EN defined set RES_W = PIX_W, residual saturated to [-2^(PIX_W-1), 2^(PIX_W-1)-1].
REQ-033 SHALL without RESER_RES_CLIP_EN set RES_W = PIX_W+1, full residual; SAD always from unclipped residual.

Structure
REQ-034 SHALL place FSM state enum, SAD_W/RES_W width functions and mode index constants (V=0, H=1, DC=2, DDL=3, DDR=4, VR=5, HD=6, VL=7, HU=8) in shared package intra_pkg.
REQ-035 SHALL instantiate one sub-module reser_abs_lane per mode computing LANES residuals and sum of absolute values.

Verification
REQ-036 SHALL cover: mb all 100, pred mode k all 100+k, full mask -> best_mode 0, best_sad 0, sad_valid 10 cycles after beat 4.
REQ-037 SHALL cover: mb 0, pred all 255 for mode 3, others 0, mask 0x008 -> best_mode 3, best_sad 4080, none_avail 0.
REQ-038 SHALL cover: modes 1 and 4 both SAD 16, others 32, full mask -> best_mode 1 (tie rule).
REQ-039 SHALL cover: mb 0, pred 255 -> res -255 without macro, -128 with RESER_RES_CLIP_EN; best_sad 4080 both.
REQ-040 SHALL cover: sad_ready held low 5 cycles -> in_ready low, outputs stable; mask 0 -> none_avail 1, best_sad 4095.
REQ-041 SHALL cover: reset asserted after beat 2 -> all outputs zero; next 4 beats form a fresh block with correct SAD.
